fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the word memory `mem`.
- Owns the program counter and drives the memory read port: address plus read strobe; write strobe tied low.
- Captures the 32-bit word the memory returns combinationally into a one-entry instruction buffer.
- Hands buffered words to decode over a valid/ready handshake; supports redirect (branch/jump) and flags misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0080, PC value after reset; bits [1:0] must be 0.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on rising edge of clk.
- enable  input  1  fetch permitted when 1.
- mem_addr  output  32  address to mem; equals pc.
- mem_rd  output  1  read strobe to mem.
- mem_wr  output  1  write strobe to mem; constant 0.
- mem_data  input  32  word from mem; valid in the same cycle as mem_addr/mem_rd.
- redirect_valid  input  1  load redirect_pc into pc this cycle.
- redirect_pc  input  32  new fetch address.
- ins_valid  output  1  ins_word/ins_pc hold an instruction.
- ins_ready  input  1  decode accepts the instruction this cycle.
- ins_word  output  32  fetched instruction.
- ins_pc  output  32  address ins_word was fetched from.
- fault  output  1  misaligned redirect occurred; sticky.
- fault_pc  output  32  offending redirect address.
- fetch_count  output  32  number of words loaded into the buffer.

Behaviour:
Reset:
- rst_n=0 at a rising edge sets: pc=RESET_PC, state=IDLE, ins_valid=0, ins_word=0, ins_pc=0, fault=0, fault_pc=0, fetch_count=0.
- Reset wins over every other input, including mid-fetch and in FAULT.

State machine (IDLE, RUN, FAULT):
- IDLE -> RUN when enable=1; no fetch occurs in the IDLE cycle.
- RUN -> FAULT on a misaligned redirect.
- FAULT is terminal until reset.

Outputs:
- mem_addr = pc at all times.
- mem_wr = 0 at all times.
- mem_rd = load (combinational).
- load = (state==RUN) & enable & !redirect_valid & (!ins_valid | ins_ready).

On load (end of cycle):
- ins_word <= mem_data, ins_pc <= pc, ins_valid <= 1.
- pc <= pc + PC_STEP, modulo 2^32: 0xFFFF_FFFC wraps to 0.
- fetch_count <= fetch_count + 1, wrapping.
- Sustained throughput is 1 word/cycle while ins_ready=1.
- Latency: a word is presented on ins_* exactly 1 cycle after its address is driven.

Handshake:
- Transfer occurs when ins_valid & ins_ready.
- Transfer without load in the same cycle: ins_valid <= 0.
- ins_valid=1 & ins_ready=0: ins_word/ins_pc hold stable, pc holds, mem_rd=0.

Redirect (state RUN, highest priority after reset):
- Flushes the buffer: ins_valid <= 0, even if ins_ready=1 that cycle. The word presented that cycle counts as transferred only if ins_ready=1; decode is responsible for discarding it.
- Aligned target (redirect_pc[1:0]==0): pc <= redirect_pc. The first word from the new pc is loaded the following cycle.
- Misaligned target: fault <= 1, fault_pc <= redirect_pc, state <= FAULT, pc unchanged.
- redirect_valid is ignored in IDLE and FAULT.

FAULT:
- mem_rd=0, ins_valid=0.
- fault and fault_pc hold; fetch_count holds.

enable=0 in RUN:
- No new loads.
- A held word remains valid and can still be transferred.
- Redirects are still honoured.

Decomposition:
- Shared package: state encoding (IDLE/RUN/FAULT), WORD_W=32, default RESET_PC, alignment-check constant 2'b00.
- No sub-module is required. The instruction buffer (valid, word, pc) is simple enough to live inline; an optional `fetch_buffer` one-entry register slice may be factored out if decode later needs a skid stage.

Test Plan:
1. Reset then enable=1, ins_ready=1, mem preloaded with word k at 0x80+4k:
   - mem_addr steps 0x80, 0x84, 0x88, … one per cycle.
   - ins_pc/ins_word trail by 1 cycle.
   - fetch_count=10 after 10 loads.
2. Backpressure: ins_ready=0 for 3 cycles after the first load:
   - ins_word at 0x80 held stable.
   - mem_rd=0, pc=0x84 throughout.
   - Resuming ins_ready=1 yields 0x84 next, no duplicate, no skip.
3. Redirect to 0x200 while ins_valid=1 with ins_ready=0:
   - ins_valid drops next cycle.
   - ins_pc=0x200 one cycle later; count increments only on loads.
4. Redirect to 0x202:
   - fault=1, fault_pc=0x202, ins_valid=0, mem_rd=0 persist.
   - Further redirects ignored until rst_n=0 restores pc=0x80, fault=0.
5. PC wrap: redirect to 0xFFFF_FFFC, run 2 loads:
   - ins_pc=0xFFFF_FFFC then 0x0000_0000.
6. Mid-stream rst_n=0 for one cycle during continuous fetch at pc=0x90:
   - All outputs at reset values next cycle, state IDLE.
   - Fetch restarts at 0x80 after enable.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the state encoding, data width and alignment helpers.
package fetch_unit_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0080;

    localparam logic [1:0] ALIGN_OK = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetchState_t;

    function automatic logic isAligned(input logic [WORD_W-1:0] addr);
        return addr[1:0] == ALIGN_OK;
    endfunction

endpackage

// File: rtl/fetch_unit_buffer.sv
// One-entry instruction buffer between fetch and decode.
// Flush has priority over a load; a transfer without a load empties it.
module fetch_unit_buffer
    import fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              load,
    input  logic              take,
    input  logic [WORD_W-1:0] wordIn,
    input  logic [WORD_W-1:0] pcIn,
    output logic              valid,
    output logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            word  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            word  <= wordIn;
            pc    <= pcIn;
        end else if (take) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the word memory and
// presents fetched words to decode over a valid/ready handshake.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [WORD_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [WORD_W-1:0] mem_data,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [WORD_W-1:0] ins_word,
    output logic [WORD_W-1:0] ins_pc,
    output logic              fault,
    output logic [WORD_W-1:0] fault_pc,
    output logic [WORD_W-1:0] fetch_count
);

    localparam logic [WORD_W-1:0] STEP = WORD_W'(PC_STEP);

    fetchState_t       state;
    logic [WORD_W-1:0] pc;
    logic              running;
    logic              load;
    logic              flush;
    logic              take;

    assign running = (state == RUN);
    assign flush   = running & redirect_valid;
    assign take    = ins_valid & ins_ready;
    assign load    = running & enable & ~redirect_valid
                   & (~ins_valid | ins_ready);

    assign mem_addr = pc;
    assign mem_rd   = load;
    assign mem_wr   = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            fault       <= 1'b0;
            fault_pc    <= '0;
            fetch_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable) state <= RUN;
                end
                RUN: begin
                    if (redirect_valid) begin
                        if (isAligned(redirect_pc)) begin
                            pc <= redirect_pc;
                        end else begin
                            fault    <= 1'b1;
                            fault_pc <= redirect_pc;
                            state    <= FAULT;
                        end
                    end else if (load) begin
                        pc          <= pc + STEP;
                        fetch_count <= fetch_count + 1'b1;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_unit_buffer uBuffer (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .load   (load),
        .take   (take),
        .wordIn (mem_data),
        .pcIn   (pc),
        .valid  (ins_valid),
        .word   (ins_word),
        .pc     (ins_pc)
    );

endmodule
